// File: rtl/regf_wb_seq.sv
// regf_wb_seq: write-back sequencer for the register file's single write port.
// ALU results always win the port. Formatted load responses bypass straight
// to the port when it is free and nothing is queued, otherwise they wait in
// a small in-order FIFO. A pending-load scoreboard lets decode stall on
// load-use hazards.
module regf_wb_seq #(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int XLEN          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_wr_en,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_value,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  output logic [31:0]     busy_mask,
  output logic            write_regf_en_r,
  output logic [4:0]      addr_rd_r,
  output logic [XLEN-1:0] rd_value_
);

  localparam int PW = $clog2(LD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LD_FIFO_DEPTH);
  localparam int EW = 5 + XLEN;

  // Byte/half lane extraction and extension for RISC-V load widths.
  // Unused funct3 encodings fall back to a full word.
  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                               input logic [1:0] lo,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  logic [EW-1:0]   fifo_mem [LD_FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ld_ready_q, ld_ready_d;
  logic [31:0]     busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_rd_q, wr_rd_d;
  logic [XLEN-1:0] wr_val_q, wr_val_d;

  logic            fifo_empty;
  logic            ld_accept;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] ld_fmt;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_val;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  assign fifo_empty = (count_q == '0);
  assign ld_accept  = ld_valid & ld_ready_q;
  assign ld_fmt     = fmt_load(ld_funct3, ld_addr_lo, ld_rdata);
  assign head_rd    = fifo_mem[rd_ptr_q][EW-1:XLEN];
  assign head_val   = fifo_mem[rd_ptr_q][XLEN-1:0];

  assign ld_ready        = ld_ready_q;
  assign busy_mask       = busy_q;
  assign write_regf_en_r = wr_en_q;
  assign addr_rd_r       = wr_rd_q;
  assign rd_value_       = wr_val_q;

  // Port arbitration (ALU > FIFO head > bypass), FIFO bookkeeping, scoreboard.
  always_comb begin
    wr_en_d  = 1'b0;
    wr_rd_d  = wr_rd_q;
    wr_val_d = wr_val_q;
    pop      = 1'b0;
    push     = 1'b0;
    clr_mask = '0;
    set_mask = '0;

    if (alu_wr_en) begin
      // x0 is never presented enabled: the register file forwards on address match.
      wr_en_d  = (alu_rd != 5'd0);
      wr_rd_d  = alu_rd;
      wr_val_d = alu_value;
      push     = ld_accept;
    end else if (!fifo_empty) begin
      pop      = 1'b1;
      wr_en_d  = (head_rd != 5'd0);
      wr_rd_d  = head_rd;
      wr_val_d = head_val;
      if (head_rd != 5'd0) clr_mask[head_rd] = 1'b1;
      // A new load must queue behind older entries to keep order.
      push     = ld_accept;
    end else if (ld_accept) begin
      wr_en_d  = (ld_rd != 5'd0);
      wr_rd_d  = ld_rd;
      wr_val_d = ld_fmt;
      if (ld_rd != 5'd0) clr_mask[ld_rd] = 1'b1;
    end

    if (ld_issue && (ld_issue_rd != 5'd0)) set_mask[ld_issue_rd] = 1'b1;
    // Set wins over a same-cycle clear of the same bit.
    busy_d = (busy_q & ~clr_mask) | set_mask;

    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    ld_ready_d = (count_d < DEPTH_C);
  end

  // State registers; reset drops queued loads and pending scoreboard bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_rd_q    <= '0;
      wr_val_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_rd_q    <= wr_rd_d;
      wr_val_q   <= wr_val_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {ld_rd, ld_fmt};
  end

endmodule
